// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron
// Purpose  : Leaky integrate-and-fire neuron. Integrates weighted synaptic
//            current into an 8-bit membrane potential and applies a
//            shift-based leak every cycle. It emits a one-cycle spike when
//            the threshold is reached, then ignores its input for a fixed
//            refractory period.
// Ports    : clk           - clock, rising edge
//            rst_n         - asynchronous active-low reset
//            ena           - enable; low freezes state and clears spike
//            current_in    - 8-bit unsigned synaptic current
//            current_valid - qualifies current_in for this cycle
//            spike         - registered one-cycle fire pulse
//            membrane      - registered membrane potential
//            refractory    - high while in the refractory state
// Config   : LIF_LEAK_EN - when defined, the leak term V >> LEAK_SHIFT is
//            applied. When undefined, the leak is zero and the block is a
//            pure integrate-and-fire accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron #(
    parameter int THRESHOLD      = 200,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] current_in,
    input  logic       current_valid,
    output logic       spike,
    output logic [7:0] membrane,
    output logic       refractory
);

`ifdef LIF_LEAK_EN
    localparam logic LEAK_ON = 1'b1;
`else
    localparam logic LEAK_ON = 1'b0;
`endif

    localparam logic [8:0] THRESH9 = 9'(THRESHOLD);
    localparam logic [3:0] REFRACT4 = 4'(REFRACT_CYCLES);

    typedef enum logic [0:0] {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } state_t;

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    logic [7:0] v, next_v;
    logic       spike_q, next_spike;

    logic [7:0] leak;
    logic [7:0] cur_term;
    logic [8:0] sum;

    // The leak can never exceed V, and V - leak + current is at most
    // 255 + 255, so the 9-bit sum cannot wrap.
    assign leak     = LEAK_ON ? (v >> LEAK_SHIFT) : 8'd0;
    assign cur_term = current_valid ? current_in : 8'd0;
    assign sum      = {1'b0, v} - {1'b0, leak} + {1'b0, cur_term};

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_v     = v;
        next_spike = 1'b0;      // a pulse never outlives one cycle
        if (ena) begin
            case (state)
                INTEGRATE: begin
                    if (sum >= THRESH9) begin
                        next_v     = 8'd0;
                        next_spike = 1'b1;
                        if (REFRACT4 != 4'd0) begin
                            next_state = REFRACT;
                            next_cnt   = REFRACT4;
                        end
                    end else begin
                        next_v = sum[7:0];
                    end
                end
                REFRACT: begin
                    // Input is ignored. Leave on the last counted cycle, so
                    // the cycle after that integrates again.
                    next_v = 8'd0;
                    if (cnt == 4'd1) begin
                        next_state = INTEGRATE;
                        next_cnt   = 4'd0;
                    end else begin
                        next_cnt = cnt - 4'd1;
                    end
                end
                default: begin
                    next_state = INTEGRATE;
                    next_cnt   = 4'd0;
                    next_v     = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INTEGRATE;
            cnt     <= 4'd0;
            v       <= 8'd0;
            spike_q <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            v       <= next_v;
            spike_q <= next_spike;
        end
    end

    assign spike      = spike_q;
    assign membrane   = v;
    assign refractory = (state == REFRACT);

endmodule
`default_nettype wire
